sram_like_arbiter: RTL and testbench

Two-to-one arbiter sharing a single sram-like memory port between the fetch-side (inst) and load/store-side (data) requesters of the five-stage core. It sits between `mycpu_top`'s `inst_sram_*`/`data_sram_*` ports and the single memory-side bridge. It does three things:
- grants one request per address handshake;
- locks the grant until `addr_ok`;
- tracks outstanding transactions in order so that every `data_ok`/`rdata` returns to the requester that issued it.

---
 rtl/sram_like_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - two-to-one sram-like arbiter with in-order response routing (optional ARB_RR_EN)
module sram_like_arbiter #(
    parameter int MAX_OUTST = 4,
    parameter int OUTST_W   = $clog2(MAX_OUTST)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] LOCK_NONE = 2'd0;
    localparam logic [1:0] LOCK_INST = 2'd1;
    localparam logic [1:0] LOCK_DATA = 2'd2;
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;
    localparam logic [OUTST_W:0] FULL_CNT = (OUTST_W+1)'(MAX_OUTST);

    logic [1:0]           gnt_lock, gnt_lock_nxt;
    logic                 pick_inst, pick_data;
    logic                 gnt_inst, gnt_data, gnt_req;
    logic [MAX_OUTST-1:0] fifo_q;
    logic [OUTST_W-1:0]   wr_ptr, rd_ptr;
    logic [OUTST_W:0]     count;
    logic                 fifo_full, fifo_empty, push, pop, head_src;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign push       = mem_req && mem_addr_ok;
    assign pop        = mem_data_ok && !fifo_empty;
    assign head_src   = fifo_q[rd_ptr];

`ifdef ARB_RR_EN
    logic last_src;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_src <= SRC_INST;
        else if (push)
            last_src <= gnt_data ? SRC_DATA : SRC_INST;
    end

    always_comb begin
        pick_data = data_req;
        pick_inst = inst_req && !data_req;
        if (inst_req && data_req) begin
            pick_data = (last_src == SRC_INST);
            pick_inst = !pick_data;
        end
    end
`else
    always_comb begin
        pick_data = data_req;
        pick_inst = inst_req && !data_req;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            gnt_lock <= LOCK_NONE;
        else
            gnt_lock <= gnt_lock_nxt;
    end

    // A stalled address phase pins the grant so the payload stays stable until addr_ok.
    always_comb begin
        gnt_lock_nxt = gnt_lock;
        case (gnt_lock)
            LOCK_NONE: if (mem_req && !mem_addr_ok) gnt_lock_nxt = gnt_data ? LOCK_DATA : LOCK_INST;
            default:   if (push) gnt_lock_nxt = LOCK_NONE;
        endcase
    end

    // Grant is gated by resetn so outputs drop as soon as reset asserts.
    always_comb begin
        gnt_inst  = 1'b0;
        gnt_data  = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (resetn) begin
            case (gnt_lock)
                LOCK_INST: gnt_inst = 1'b1;
                LOCK_DATA: gnt_data = 1'b1;
                default: begin
                    gnt_inst = pick_inst;
                    gnt_data = pick_data;
                end
            endcase
        end
        if (gnt_data) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (gnt_inst) begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_wstrb = inst_wstrb;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end
        gnt_req      = (gnt_inst && inst_req) || (gnt_data && data_req);
        mem_req      = gnt_req && !fifo_full;
        inst_addr_ok = gnt_inst && mem_req && mem_addr_ok;
        data_addr_ok = gnt_data && mem_req && mem_addr_ok;
        inst_data_ok = pop && (head_src == SRC_INST);
        data_data_ok = pop && (head_src == SRC_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= gnt_data ? SRC_DATA : SRC_INST;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (resetn && mem_data_ok && fifo_empty)
            $display("sram_like_arbiter: protocol error, mem_data_ok with nothing outstanding at %0t", $time);
    end
`endif
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - directed self-checking bench for sram_like_arbiter
module tb_sram_like_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    int          checks = 0;
    int          errors = 0;
    logic        exp_data;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_OUTST(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        {inst_req, inst_wr, data_req, data_wr, mem_addr_ok, mem_data_ok} = '0;
        {inst_size, data_size, inst_wstrb, data_wstrb} = '0;
        {inst_addr, inst_wdata, data_addr, data_wdata, mem_rdata} = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mem_req", 32'(mem_req), 0);
        check_eq("rst_count", 32'(dut.count), 0);
        check_eq("rst_lock", 32'(dut.gnt_lock), 0);
        resetn = 1'b1;

        // single read
        step();
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
        #1;
        check_eq("rd_mem_req", 32'(mem_req), 1);
        check_eq("rd_mem_addr", mem_addr, 32'h1C00_0000);
        check_eq("rd_inst_addr_ok", 32'(inst_addr_ok), 1);
        check_eq("rd_data_addr_ok", 32'(data_addr_ok), 0);
        step();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        #1;
        check_eq("rd_count1", 32'(dut.count), 1);
        step();
        step();
        mem_data_ok = 1'b1; mem_rdata = 32'h02C0_0000;
        #1;
        check_eq("rd_inst_data_ok", 32'(inst_data_ok), 1);
        check_eq("rd_data_data_ok", 32'(data_data_ok), 0);
        check_eq("rd_inst_rdata", inst_rdata, 32'h02C0_0000);
        step();
        mem_data_ok = 1'b0;
        #1;
        check_eq("rd_count0", 32'(dut.count), 0);

        // contention, fixed priority
        step();
        inst_req = 1'b1; inst_addr = 32'h1C00_0100;
        data_req = 1'b1; data_addr = 32'h1C0F_0000; mem_addr_ok = 1'b1;
        #1;
        check_eq("ct_mem_addr_d", mem_addr, 32'h1C0F_0000);
        check_eq("ct_data_addr_ok", 32'(data_addr_ok), 1);
        check_eq("ct_inst_addr_ok0", 32'(inst_addr_ok), 0);
        step();
        data_req = 1'b0;
        #1;
        check_eq("ct_mem_addr_i", mem_addr, 32'h1C00_0100);
        check_eq("ct_inst_addr_ok", 32'(inst_addr_ok), 1);
        step();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        #1;
        check_eq("ct_count2", 32'(dut.count), 2);
        check_eq("ct_resp1_data", 32'(data_data_ok), 1);
        check_eq("ct_resp1_inst", 32'(inst_data_ok), 0);
        step();
        #1;
        check_eq("ct_resp2_inst", 32'(inst_data_ok), 1);
        check_eq("ct_resp2_data", 32'(data_data_ok), 0);
        step();
        mem_data_ok = 1'b0;
        #1;
        check_eq("ct_count0", 32'(dut.count), 0);

        // grant lock across three stalled cycles
        step();
        inst_req = 1'b1; inst_addr = 32'h1C00_0200; mem_addr_ok = 1'b0;
        #1;
        check_eq("lk_addr_c0", mem_addr, 32'h1C00_0200);
        for (int i = 1; i < 4; i++) begin
            step();
            data_req = 1'b1; data_addr = 32'h1C0F_0040;
            if (i == 3) mem_addr_ok = 1'b1;
            #1;
            check_eq("lk_addr_held", mem_addr, 32'h1C00_0200);
        end
        check_eq("lk_inst_addr_ok", 32'(inst_addr_ok), 1);
        check_eq("lk_data_addr_ok0", 32'(data_addr_ok), 0);
        step();
        inst_req = 1'b0;
        #1;
        check_eq("lk_addr_data", mem_addr, 32'h1C0F_0040);
        check_eq("lk_data_addr_ok", 32'(data_addr_ok), 1);
        step();
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        #1;
        check_eq("lk_resp_inst", 32'(inst_data_ok), 1);
        step();
        #1;
        check_eq("lk_resp_data", 32'(data_data_ok), 1);
        step();
        mem_data_ok = 1'b0;
        #1;
        check_eq("lk_count0", 32'(dut.count), 0);

        // FIFO full; 5 pushes and 5 pops so far
        step();
        inst_req = 1'b1; inst_wr = 1'b1; inst_size = 2'd2; inst_wstrb = 4'hF;
        inst_addr = 32'h1C00_1000; inst_wdata = 32'hA5A5_0F0F; mem_addr_ok = 1'b1;
        #1;
        check_eq("fl_mem_wdata", mem_wdata, 32'hA5A5_0F0F);
        check_eq("fl_mem_wr", 32'(mem_wr), 1);
        check_eq("fl_mem_wstrb", 32'(mem_wstrb), 32'hF);
        for (int i = 0; i < 4; i++) begin
            check_eq("fl_inst_addr_ok", 32'(inst_addr_ok), 1);
            step();
            #1;
        end
        check_eq("fl_count4", 32'(dut.count), 4);
        check_eq("fl_mem_req0", 32'(mem_req), 0);
        check_eq("fl_inst_addr_ok0", 32'(inst_addr_ok), 0);
        check_eq("fl_wr_ptr", 32'(dut.wr_ptr), 1);
        mem_data_ok = 1'b1;
        #1;
        check_eq("fl_stall_on_pop", 32'(mem_req), 0);
        step();
        mem_data_ok = 1'b0;
        #1;
        check_eq("fl_count3", 32'(dut.count), 3);
        check_eq("fl_mem_req1", 32'(mem_req), 1);
        step();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = '0; inst_wstrb = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("fl_drain_inst", 32'(inst_data_ok), 1);
            step();
        end
        mem_data_ok = 1'b0;
        #1;
        check_eq("fl_count0", 32'(dut.count), 0);
        check_eq("fl_wr_ptr_wrap", 32'(dut.wr_ptr), 2);
        check_eq("fl_rd_ptr_wrap", 32'(dut.rd_ptr), 2);

        // asynchronous reset with count=2 and lock=DATA
        step();
        data_req = 1'b1; data_addr = 32'h1C0F_0080; mem_addr_ok = 1'b1;
        step();
        step();
        mem_addr_ok = 1'b0;
        step();
        #1;
        check_eq("ar_pre_count", 32'(dut.count), 2);
        check_eq("ar_pre_lock", 32'(dut.gnt_lock), 2);
        #2;
        resetn = 1'b0; mem_data_ok = 1'b1;
        #1;
        check_eq("ar_mem_req", 32'(mem_req), 0);
        check_eq("ar_data_addr_ok", 32'(data_addr_ok), 0);
        check_eq("ar_mem_addr", mem_addr, 0);
        check_eq("ar_data_data_ok", 32'(data_data_ok), 0);
        check_eq("ar_count", 32'(dut.count), 0);
        check_eq("ar_lock", 32'(dut.gnt_lock), 0);
        data_req = 1'b0; mem_data_ok = 1'b0;
        step();
        resetn = 1'b1;
        step();
        check_eq("ar_post_count", 32'(dut.count), 0);
        check_eq("ar_post_lock", 32'(dut.gnt_lock), 0);

        // continuous contention: alternating with ARB_RR_EN, data always wins otherwise
        inst_req = 1'b1; inst_addr = 32'h1C00_3000;
        data_req = 1'b1; data_addr = 32'h1C0F_3000; mem_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            exp_data = (i % 2 == 0);
`else
            exp_data = 1'b1;
`endif
            #1;
            check_eq("cc_data_addr_ok", 32'(data_addr_ok), 32'(exp_data));
            check_eq("cc_inst_addr_ok", 32'(inst_addr_ok), 32'(!exp_data));
            check_eq("cc_mem_addr", mem_addr, exp_data ? 32'h1C0F_3000 : 32'h1C00_3000);
            step();
        end
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        repeat (4) step();
        mem_data_ok = 1'b0;
        #1;
        check_eq("cc_count0", 32'(dut.count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
